// File: rtl/mux4x8_tri_lane.sv
// ----------------------------------------------------------------------------
// mux4x8_tri_lane
//
// Purpose:
//   Three independent 4:1 multiplexer lanes (sv, v, vhd). Each lane is WIDTH
//   bits wide and registers its output. Each lane is built in a different
//   coding style so the three implementations can be compared side by side:
//     - lane sv  : case statement inside the clocked block
//     - lane v   : nested conditional operator inside the clocked block
//     - lane vhd : combinational case into a next-value word, then a register
//   All three lanes behave the same way.
//
// Ports (top):
//   clk                         system clock; all state changes on the rising edge
//   reset                       synchronous, active-high; clears every y_* output
//   d0_X..d3_X [WIDTH-1:0]      lane X data words; s_X selects d<s_X>_X
//   s_X        [1:0]            lane X select
//   y_X        [WIDTH-1:0]      lane X registered output, one cycle after d/s
//   where X is one of sv, v, vhd.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// mux4_lane_case
//   Registered 4:1 mux written as a case statement in the clocked block.
//   Ports: clk, reset, d0..d3 [WIDTH-1:0], s [1:0], y [WIDTH-1:0] (registered).
// ----------------------------------------------------------------------------
module mux4_lane_case #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignment, so every flop samples its inputs
            // before any register takes its new value.
            y <= '0;
        end else begin
            case (s)
                2'b00:   y <= d0;
                2'b01:   y <= d1;
                2'b10:   y <= d2;
                default: y <= d3;
            endcase
        end
    end

endmodule

// ----------------------------------------------------------------------------
// mux4_lane_ternary
//   Registered 4:1 mux written as a nested conditional expression.
//   Ports: clk, reset, d0..d3 [WIDTH-1:0], s [1:0], y [WIDTH-1:0] (registered).
// ----------------------------------------------------------------------------
module mux4_lane_ternary #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
        end else begin
            // s[1] picks the upper or lower pair, and s[0] picks within the pair.
            y <= s[1] ? (s[0] ? d3 : d2)
                      : (s[0] ? d1 : d0);
        end
    end

endmodule

// ----------------------------------------------------------------------------
// mux4_lane_split
//   4:1 mux with the selection in a separate combinational block that feeds
//   a plain register.
//   Ports: clk, reset, d0..d3 [WIDTH-1:0], s [1:0], y [WIDTH-1:0] (registered).
// ----------------------------------------------------------------------------
module mux4_lane_split #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sel_word;

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves
        // sel_word unassigned and no latch is inferred.
        sel_word = d3;
        case (s)
            2'b00:   sel_word = d0;
            2'b01:   sel_word = d1;
            2'b10:   sel_word = d2;
            default: sel_word = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
        end else begin
            y <= sel_word;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// mux4x8_tri_lane (top)
//   Instantiates one lane of each style. The lanes share only clk and reset.
// ----------------------------------------------------------------------------
module mux4x8_tri_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    // lane sv
    input  logic [WIDTH-1:0] d0_sv,
    input  logic [WIDTH-1:0] d1_sv,
    input  logic [WIDTH-1:0] d2_sv,
    input  logic [WIDTH-1:0] d3_sv,
    input  logic [1:0]       s_sv,
    output logic [WIDTH-1:0] y_sv,
    // lane v
    input  logic [WIDTH-1:0] d0_v,
    input  logic [WIDTH-1:0] d1_v,
    input  logic [WIDTH-1:0] d2_v,
    input  logic [WIDTH-1:0] d3_v,
    input  logic [1:0]       s_v,
    output logic [WIDTH-1:0] y_v,
    // lane vhd
    input  logic [WIDTH-1:0] d0_vhd,
    input  logic [WIDTH-1:0] d1_vhd,
    input  logic [WIDTH-1:0] d2_vhd,
    input  logic [WIDTH-1:0] d3_vhd,
    input  logic [1:0]       s_vhd,
    output logic [WIDTH-1:0] y_vhd
);

    mux4_lane_case #(.WIDTH(WIDTH)) u_lane_sv (
        .clk   (clk),
        .reset (reset),
        .d0    (d0_sv),
        .d1    (d1_sv),
        .d2    (d2_sv),
        .d3    (d3_sv),
        .s     (s_sv),
        .y     (y_sv)
    );

    mux4_lane_ternary #(.WIDTH(WIDTH)) u_lane_v (
        .clk   (clk),
        .reset (reset),
        .d0    (d0_v),
        .d1    (d1_v),
        .d2    (d2_v),
        .d3    (d3_v),
        .s     (s_v),
        .y     (y_v)
    );

    mux4_lane_split #(.WIDTH(WIDTH)) u_lane_vhd (
        .clk   (clk),
        .reset (reset),
        .d0    (d0_vhd),
        .d1    (d1_vhd),
        .d2    (d2_vhd),
        .d3    (d3_vhd),
        .s     (s_vhd),
        .y     (y_vhd)
    );

endmodule

// File: tb/tb_mux4x8_tri_lane.sv
// ----------------------------------------------------------------------------
// tb_mux4x8_tri_lane
//   Drives an 8-bit and a 16-bit instance of mux4x8_tri_lane from shared
//   stimulus. The 8-bit instance sees the low byte of each data word. Expected
//   outputs come from a reference model that indexes arrays and are queued
//   when stimulus is issued. A monitor pops and compares after every edge.
// ----------------------------------------------------------------------------
module tb_mux4x8_tri_lane;

    localparam int NL = 3;  // lanes: 0=sv, 1=v, 2=vhd

    typedef struct packed {
        logic [NL-1:0]       dc;   // lane output is don't-care this cycle
        logic [NL-1:0][7:0]  y8;
        logic [NL-1:0][15:0] y16;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d [NL][4];
    logic [1:0]  s [NL];
    logic [7:0]  y8 [NL];
    logic [15:0] y16 [NL];
    logic [NL-1:0] s_bad;  // lane select deliberately X this cycle

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux4x8_tri_lane #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .d0_sv  (d[0][0][7:0]), .d1_sv  (d[0][1][7:0]), .d2_sv  (d[0][2][7:0]), .d3_sv  (d[0][3][7:0]),
        .s_sv   (s[0]),         .y_sv   (y8[0]),
        .d0_v   (d[1][0][7:0]), .d1_v   (d[1][1][7:0]), .d2_v   (d[1][2][7:0]), .d3_v   (d[1][3][7:0]),
        .s_v    (s[1]),         .y_v    (y8[1]),
        .d0_vhd (d[2][0][7:0]), .d1_vhd (d[2][1][7:0]), .d2_vhd (d[2][2][7:0]), .d3_vhd (d[2][3][7:0]),
        .s_vhd  (s[2]),         .y_vhd  (y8[2])
    );

    mux4x8_tri_lane #(.WIDTH(16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .d0_sv  (d[0][0]), .d1_sv  (d[0][1]), .d2_sv  (d[0][2]), .d3_sv  (d[0][3]),
        .s_sv   (s[0]),    .y_sv   (y16[0]),
        .d0_v   (d[1][0]), .d1_v   (d[1][1]), .d2_v   (d[1][2]), .d3_v   (d[1][3]),
        .s_v    (s[1]),    .y_v    (y16[1]),
        .d0_vhd (d[2][0]), .d1_vhd (d[2][1]), .d2_vhd (d[2][2]), .d3_vhd (d[2][3]),
        .s_vhd  (s[2]),    .y_vhd  (y16[2])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a lane's next output is the data word its select
    // indexes, or zero under reset. Push it, then let one edge pass.
    task automatic cycle(input logic rst);
        exp_t e;
        reset = rst;
        e.dc  = rst ? '0 : s_bad;
        for (int l = 0; l < NL; l++) begin
            e.y16[l] = rst ? 16'h0000 : d[l][s[l]];
            e.y8[l]  = e.y16[l][7:0];
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_all(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input logic [1:0] sel);
        for (int l = 0; l < NL; l++) begin
            d[l][0] = w0; d[l][1] = w1; d[l][2] = w2; d[l][3] = w3;
            s[l] = sel;
        end
    endtask

    // Monitor: outputs are registered, so one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int l = 0; l < NL; l++) begin
                    if (!e.dc[l]) begin
                        check($sformatf("y8_lane%0d", l),  {8'h00, y8[l]}, {8'h00, e.y8[l]});
                        check($sformatf("y16_lane%0d", l), y16[l],        e.y16[l]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        s_bad = '0;
        set_all(16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b10);
        @(negedge clk);

        // Reset held two edges with nonzero inputs.
        cycle(1'b1);
        cycle(1'b1);

        // Select sweep on all lanes.
        for (int k = 0; k < 4; k++) begin
            set_all(16'h0000, 16'h0055, 16'h00AA, 16'h00FF, 2'(k));
            cycle(1'b0);
        end

        // Lane independence: identical data, different selects.
        s[0] = 2'b00; s[1] = 2'b01; s[2] = 2'b11;
        cycle(1'b0);

        // Latency: d2 changes between edges; output must hold until the edge.
        set_all(16'h0000, 16'h0055, 16'h00AA, 16'h00FF, 2'b10);
        cycle(1'b0);
        for (int l = 0; l < NL; l++) d[l][2] = 16'h003C;
        #1;
        for (int l = 0; l < NL; l++) check($sformatf("hold_lane%0d", l), {8'h00, y8[l]}, 16'h00AA);
        cycle(1'b0);

        // Reset mid-stream from FF, then recovery on select 01.
        set_all(16'h0000, 16'h0055, 16'h00AA, 16'h00FF, 2'b11);
        cycle(1'b0);
        cycle(1'b1);
        set_all(16'h0000, 16'h0055, 16'h00AA, 16'h00FF, 2'b01);
        cycle(1'b0);

        // Width: full 16-bit word on the wide instance.
        set_all(16'h1234, 16'h5678, 16'h9ABC, 16'hBEEF, 2'b11);
        cycle(1'b0);

        // Undefined select on lane v only; it must recover the next edge.
        s[1] = 2'bxx; s_bad = 3'b010;
        cycle(1'b0);
        s[1] = 2'b10; s_bad = '0;
        cycle(1'b0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            for (int l = 0; l < NL; l++) begin
                for (int w = 0; w < 4; w++) d[l][w] = 16'($urandom);
                s[l] = 2'($urandom_range(0, 3));
            end
            cycle(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 5 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
